// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: picks sequential, jump or taken-branch target each cycle,
// tracks one outstanding not-taken-predicted branch and pulses flush on redirect.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TAG_W    = 5,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [31:0]      fetch_pc,
  output logic             flush,
  input  logic             jmp_valid,
  input  logic [31:0]      jmp_target,
  input  logic             br_dispatch,
  input  logic [TAG_W-1:0] br_tag,
  output logic             br_busy,
  input  logic             rs_valid,
  input  logic [TAG_W-1:0] rs_tag,
  input  logic             rs_taken,
  input  logic [31:0]      rs_target,
  output logic [CNT_W-1:0] jmp_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  // state   | meaning
  // IDLE    | out of reset, no fetch yet
  // RUN     | fetching, no branch outstanding
  // BR_PEND | fetching, one branch outstanding
  // FLUSH   | redirect cycle, IFQ discards, fetch_pc holds the new target
  typedef enum logic [1:0] {IDLE, RUN, BR_PEND, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc_nxt;
  logic             pend, pend_nxt;
  logic [TAG_W-1:0] tag_q, tag_nxt;
  logic [CNT_W-1:0] jmp_cnt_nxt, mispred_cnt_nxt;
  logic             active, tag_hit, take, nt_hit, redirect;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign active      = (state != IDLE);
  assign tag_hit     = active & pend & rs_valid & (rs_tag == tag_q);
  assign take        = tag_hit & rs_taken;
  assign nt_hit      = tag_hit & ~rs_taken;
  assign redirect    = active & (take | jmp_valid);
  assign fetch_valid = (state == RUN) || (state == BR_PEND);
  assign flush       = (state == FLUSH);
  assign br_busy     = pend;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = fetch_pc;
    pend_nxt        = pend;
    tag_nxt         = tag_q;
    jmp_cnt_nxt     = jmp_cnt;
    mispred_cnt_nxt = mispred_cnt;
    if (!active) begin
      state_nxt = RUN;
    end else begin
      // a dispatch while busy is ignored so the held tag survives
      if (!pend && br_dispatch) begin
        pend_nxt = 1'b1;
        tag_nxt  = br_tag;
      end else if (nt_hit) begin
        pend_nxt = 1'b0;
      end
      if (take) begin
        pc_nxt          = {rs_target[31:2], 2'b00};
        pend_nxt        = 1'b0;
        mispred_cnt_nxt = sat_inc(mispred_cnt);
      end else if (jmp_valid) begin
        pc_nxt      = {jmp_target[31:2], 2'b00};
        jmp_cnt_nxt = sat_inc(jmp_cnt);
      end else if (fetch_valid && fetch_ready) begin
        pc_nxt = fetch_pc + 32'd4;
      end
      if (redirect)      state_nxt = FLUSH;
      else if (pend_nxt) state_nxt = BR_PEND;
      else               state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      pend        <= 1'b0;
      tag_q       <= '0;
      jmp_cnt     <= '0;
      mispred_cnt <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= pc_nxt;
      pend        <= pend_nxt;
      tag_q       <= tag_nxt;
      jmp_cnt     <= jmp_cnt_nxt;
      mispred_cnt <= mispred_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl; inputs change and outputs are checked on the falling edge.
module tb_fetch_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready, fetch_valid, flush;
  logic [31:0] fetch_pc, jmp_target, rs_target;
  logic        jmp_valid, br_dispatch, br_busy, rs_valid, rs_taken;
  logic [4:0]  br_tag, rs_tag;
  logic [15:0] jmp_cnt, mispred_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  fetch_redirect_ctrl dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .flush(flush), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .br_dispatch(br_dispatch), .br_tag(br_tag), .br_busy(br_busy), .rs_valid(rs_valid),
    .rs_tag(rs_tag), .rs_taken(rs_taken), .rs_target(rs_target), .jmp_cnt(jmp_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pc"}, fetch_pc, 32'h0);
    chk({tag, ".fv"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, ".flush"}, {31'd0, flush}, 32'd0);
    chk({tag, ".busy"}, {31'd0, br_busy}, 32'd0);
    chk({tag, ".jcnt"}, {16'd0, jmp_cnt}, 32'd0);
    chk({tag, ".mcnt"}, {16'd0, mispred_cnt}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b1; jmp_valid = 1'b0; jmp_target = '0;
    br_dispatch = 1'b0; br_tag = '0; rs_valid = 1'b0; rs_tag = '0;
    rs_taken = 1'b0; rs_target = '0;
    step(); step();
    chk_reset_vals("reset");
    rst = 1'b0;

    // 1: sequential fetch from reset
    step(); chk("t1.fv", {31'd0, fetch_valid}, 32'd1);
    chk("t1.pc0", fetch_pc, 32'h0);
    step(); chk("t1.pc4", fetch_pc, 32'h4);
    step(); chk("t1.pc8", fetch_pc, 32'h8);
    step(); chk("t1.pcC", fetch_pc, 32'hC); chk("t1.flush", {31'd0, flush}, 32'd0);

    // 2: stall holds PC
    step(); chk("t2.pc10", fetch_pc, 32'h10); fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t2.hold", fetch_pc, 32'h10);
    end
    fetch_ready = 1'b1;
    step(); chk("t2.pc14", fetch_pc, 32'h14);

    // 3: jump with misaligned target
    jmp_valid = 1'b1; jmp_target = 32'h0040_0103;
    step(); jmp_valid = 1'b0;
    chk("t3.flush", {31'd0, flush}, 32'd1);
    chk("t3.pc", fetch_pc, 32'h0040_0100);
    chk("t3.fv0", {31'd0, fetch_valid}, 32'd0);
    chk("t3.jcnt", {16'd0, jmp_cnt}, 32'd1);
    step(); chk("t3.fv1", {31'd0, fetch_valid}, 32'd1);
    chk("t3.flush0", {31'd0, flush}, 32'd0);
    chk("t3.pc_hold", fetch_pc, 32'h0040_0100);

    // 4: branch tag 3, wrong-tag resolve and a busy dispatch both ignored, then taken
    fetch_ready = 1'b0; br_dispatch = 1'b1; br_tag = 5'd3;
    step(); br_dispatch = 1'b0;
    chk("t4.busy", {31'd0, br_busy}, 32'd1);
    rs_valid = 1'b1; rs_tag = 5'd5; rs_taken = 1'b1; rs_target = 32'h300;
    br_dispatch = 1'b1; br_tag = 5'd5;
    step(); br_dispatch = 1'b0;
    chk("t4.ign_flush", {31'd0, flush}, 32'd0);
    chk("t4.ign_busy", {31'd0, br_busy}, 32'd1);
    chk("t4.ign_pc", fetch_pc, 32'h0040_0100);
    rs_tag = 5'd3; rs_target = 32'h203;
    step(); rs_valid = 1'b0;
    chk("t4.flush", {31'd0, flush}, 32'd1);
    chk("t4.pc", fetch_pc, 32'h200);
    chk("t4.busy0", {31'd0, br_busy}, 32'd0);
    chk("t4.mcnt", {16'd0, mispred_cnt}, 32'd1);
    step(); chk("t4.fv", {31'd0, fetch_valid}, 32'd1);

    // 5a: taken resolve beats a same-cycle jump
    br_dispatch = 1'b1; br_tag = 5'd7;
    step(); br_dispatch = 1'b0;
    jmp_valid = 1'b1; jmp_target = 32'h500;
    rs_valid = 1'b1; rs_tag = 5'd7; rs_taken = 1'b1; rs_target = 32'h600;
    step(); jmp_valid = 1'b0; rs_valid = 1'b0;
    chk("t5.pc", fetch_pc, 32'h600);
    chk("t5.jcnt", {16'd0, jmp_cnt}, 32'd1);
    chk("t5.mcnt", {16'd0, mispred_cnt}, 32'd2);
    chk("t5.flush", {31'd0, flush}, 32'd1);
    step(); chk("t5.fv", {31'd0, fetch_valid}, 32'd1);

    // 5b: not-taken resolve, fetch continues with no flush
    fetch_ready = 1'b1; br_dispatch = 1'b1; br_tag = 5'd2;
    step(); br_dispatch = 1'b0;
    chk("t5b.busy", {31'd0, br_busy}, 32'd1);
    chk("t5b.pc", fetch_pc, 32'h604);
    rs_valid = 1'b1; rs_tag = 5'd2; rs_taken = 1'b0; rs_target = 32'h900;
    step(); rs_valid = 1'b0;
    chk("t5b.busy0", {31'd0, br_busy}, 32'd0);
    chk("t5b.flush", {31'd0, flush}, 32'd0);
    chk("t5b.pc2", fetch_pc, 32'h608);
    step(); chk("t5b.pc3", fetch_pc, 32'h60C);

    // jump while a branch is pending keeps it pending through FLUSH
    fetch_ready = 1'b0; br_dispatch = 1'b1; br_tag = 5'd4;
    step(); br_dispatch = 1'b0;
    jmp_valid = 1'b1; jmp_target = 32'h1000;
    step(); jmp_valid = 1'b0;
    chk("tj.flush", {31'd0, flush}, 32'd1);
    chk("tj.busy", {31'd0, br_busy}, 32'd1);
    chk("tj.jcnt", {16'd0, jmp_cnt}, 32'd2);
    step(); chk("tj.fv", {31'd0, fetch_valid}, 32'd1);
    chk("tj.busy2", {31'd0, br_busy}, 32'd1);
    rs_valid = 1'b1; rs_tag = 5'd4; rs_taken = 1'b1; rs_target = 32'h2000;
    step(); rs_valid = 1'b0;
    chk("tj.pc", fetch_pc, 32'h2000);
    chk("tj.mcnt", {16'd0, mispred_cnt}, 32'd3);
    chk("tj.busy0", {31'd0, br_busy}, 32'd0);

    // 6: wrap at top of address space, then async reset mid-FLUSH
    fetch_ready = 1'b1; jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
    step(); jmp_valid = 1'b0;
    chk("t6.pc_top", fetch_pc, 32'hFFFF_FFFC);
    step(); chk("t6.pc_hold", fetch_pc, 32'hFFFF_FFFC);
    chk("t6.fv", {31'd0, fetch_valid}, 32'd1);
    step(); chk("t6.wrap", fetch_pc, 32'h0);
    br_dispatch = 1'b1; br_tag = 5'd1; jmp_valid = 1'b1; jmp_target = 32'h40;
    step(); br_dispatch = 1'b0; jmp_valid = 1'b0;
    chk("t6.flush", {31'd0, flush}, 32'd1);
    chk("t6.busy", {31'd0, br_busy}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("t6.async");
    step(); rst = 1'b0;
    step(); chk("t6.run", {31'd0, fetch_valid}, 32'd1);
    chk("t6.run_pc", fetch_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
